// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ROM window, reset vector, fetch state encoding,
// fetch entry layout and instruction-length decode helpers.
package cpu_pkg;

  localparam logic [15:0] RESET_VECTOR = 16'h8000;
  localparam logic [15:0] ROM_BASE     = 16'h8000;
  localparam logic [15:0] ROM_LAST     = 16'hFFFC;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  len;
    logic [15:0] pc;
  } fetch_entry_t;

  // Opcode bits [7:6] encode length-1.
  function automatic logic [2:0] len_from_op(input logic [1:0] op);
    return {1'b0, op} + 3'd1;
  endfunction

  // Zero every byte at or beyond len.
  function automatic logic [31:0] mask_bytes(input logic [31:0] raw, input logic [2:0] len);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < {29'd0, len}) m[8*i +: 8] = 8'hFF;
    end
    return raw & m;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a fetched instruction that arrives while the
// output register is occupied and not being consumed.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         drain,
  input  fetch_entry_t din,
  output logic         valid,
  output fetch_entry_t dout
);

  // Flush wins; load and drain are never requested together by the fetch unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of the 32 KiB ROM: one outstanding request,
// length decode, PC advance, output register + skid, redirect and fault handling.
module fetch_unit
  import cpu_pkg::fetch_state_t, cpu_pkg::fetch_entry_t, cpu_pkg::S_FETCH, cpu_pkg::S_FAULT,
         cpu_pkg::len_from_op, cpu_pkg::mask_bytes;
#(
  parameter logic [15:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
  parameter logic [15:0] ROM_BASE     = cpu_pkg::ROM_BASE,
  parameter logic [15:0] ROM_LAST     = cpu_pkg::ROM_LAST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rom_a,
  output logic        rom_re,
  input  logic [7:0]  rom_q0,
  input  logic [7:0]  rom_q1,
  input  logic [7:0]  rom_q2,
  input  logic [7:0]  rom_q3,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [2:0]  instr_len,
  output logic [15:0] instr_pc,
  output logic        fault,
  output logic [15:0] fault_pc
);

  fetch_state_t state;
  logic [15:0]  fetch_pc;
  logic [15:0]  resp_pc;
  logic         inflight;

  logic         resp_fire;
  logic [2:0]   resp_len;
  logic [15:0]  next_pc;
  logic [15:0]  target;
  logic         consume;
  logic         skid_valid;
  logic         skid_load;
  logic         skid_drain;
  logic         skid_busy_next;
  logic         in_range;
  logic         want_issue;
  logic         issue;
  fetch_entry_t resp_entry;
  fetch_entry_t skid_entry;

  // Response decode, routing and issue decision for this cycle.
  // A redirect kills the response arriving in the same cycle.
  always_comb begin
    resp_fire      = inflight && !redirect_valid;
    resp_len       = len_from_op(rom_q0[7:6]);
    next_pc        = resp_pc + {13'd0, resp_len};
    target         = inflight ? next_pc : fetch_pc;
    resp_entry     = '{data: mask_bytes({rom_q3, rom_q2, rom_q1, rom_q0}, resp_len),
                       len: resp_len, pc: resp_pc};
    consume        = instr_valid && instr_ready;
    skid_load      = resp_fire && instr_valid && !consume;
    skid_drain     = consume && skid_valid;
    skid_busy_next = (skid_valid && !consume) || skid_load;
    in_range       = (target >= ROM_BASE) && (target <= ROM_LAST);
    want_issue     = (state == S_FETCH) && !redirect_valid && !skid_busy_next;
    issue          = want_issue && in_range;
    // Reset gating keeps the ROM port quiet while rst_n is held low.
    rom_re         = issue && rst_n;
    rom_a          = rom_re ? target : '0;
  end

  // PC, outstanding-request tracking, fault capture and fetch state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_VECTOR;
      resp_pc  <= '0;
      inflight <= 1'b0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      state    <= S_FETCH;
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      fault    <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) resp_pc <= target;
      if (inflight) fetch_pc <= next_pc;
      if (want_issue && !in_range) begin
        state    <= S_FAULT;
        fault    <= 1'b1;
        fault_pc <= target;
      end
    end
  end

  // Output register: skid drains first, then a new response; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_len   <= '0;
      instr_pc    <= '0;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
    end else if (skid_drain) begin
      instr_valid <= 1'b1;
      instr_data  <= skid_entry.data;
      instr_len   <= skid_entry.len;
      instr_pc    <= skid_entry.pc;
    end else if (resp_fire && (!instr_valid || consume)) begin
      instr_valid <= 1'b1;
      instr_data  <= resp_entry.data;
      instr_len   <= resp_entry.len;
      instr_pc    <= resp_entry.pc;
    end else if (consume) begin
      instr_valid <= 1'b0;
    end
  end

  fetch_skid u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .load  (skid_load),
    .drain (skid_drain),
    .din   (resp_entry),
    .valid (skid_valid),
    .dout  (skid_entry)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle-latency ROM model and a
// scoreboard of expected delivered instructions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rom_a;
  logic        rom_re;
  logic [7:0]  rom_q0 = '0, rom_q1 = '0, rom_q2 = '0, rom_q3 = '0;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [2:0]  instr_len;
  logic [15:0] instr_pc;
  logic        fault;
  logic [15:0] fault_pc;

  logic [7:0] mem [0:65535];

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  len;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_a          (rom_a),
    .rom_re         (rom_re),
    .rom_q0         (rom_q0),
    .rom_q1         (rom_q1),
    .rom_q2         (rom_q2),
    .rom_q3         (rom_q3),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_len      (instr_len),
    .instr_pc       (instr_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // ROM model: request sampled at the edge, bytes valid the following cycle.
  always @(posedge clk) begin
    if (rom_re) begin
      rom_q0 <= mem[rom_a];
      rom_q1 <= mem[rom_a + 16'd1];
      rom_q2 <= mem[rom_a + 16'd2];
      rom_q3 <= mem[rom_a + 16'd3];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc, input logic [2:0] len);
    exp_t e;
    logic [15:0] a;
    e.pc   = pc;
    e.len  = len;
    e.data = '0;
    for (int i = 0; i < int'(len); i++) begin
      a = pc + 16'(i);
      e.data[8*i +: 8] = mem[a];
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every accepted instruction must match the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pc", {16'd0, instr_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc",   {16'd0, instr_pc}, {16'd0, e.pc});
        chk("sb_len",  {29'd0, instr_len}, {29'd0, e.len});
        chk("sb_data", instr_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h8000] = 8'h00; mem[16'h8001] = 8'h41; mem[16'h8002] = 8'h5A;
    mem[16'h8003] = 8'h82; mem[16'h8004] = 8'h11; mem[16'h8005] = 8'h22;
    mem[16'h8006] = 8'hC3; mem[16'h8007] = 8'h33; mem[16'h8008] = 8'h44;
    mem[16'h8009] = 8'h55;
    mem[16'h9000] = 8'h80; mem[16'h9001] = 8'hAB; mem[16'h9002] = 8'hCD;
    mem[16'h9003] = 8'hEF;
    mem[16'hFFFB] = 8'h00; mem[16'hFFFC] = 8'hC0; mem[16'hFFFD] = 8'h11;
    mem[16'hFFFE] = 8'h22; mem[16'hFFFF] = 8'h33;

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

    // Reset state
    #25;
    chk("rst_rom_re", {31'd0, rom_re}, 32'd0);
    chk("rst_rom_a", {16'd0, rom_a}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_pc", {16'd0, fault_pc}, 32'd0);

    // Test 1: streaming from reset vector
    push_exp(16'h8000, 3'd1); push_exp(16'h8001, 3'd2);
    push_exp(16'h8003, 3'd3); push_exp(16'h8006, 3'd4);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("t1_a0", {16'd0, rom_a}, 32'h8000);
    chk("t1_re0", {31'd0, rom_re}, 32'd1);
    tick(); #1; chk("t1_a1", {16'd0, rom_a}, 32'h8001);
    chk("t1_nv1", {31'd0, instr_valid}, 32'd0);
    tick(); #1; chk("t1_a2", {16'd0, rom_a}, 32'h8003);
    chk("t1_pc2", {16'd0, instr_pc}, 32'h8000);
    chk("t1_data2", instr_data, 32'h0000_0000);
    tick(); #1; chk("t1_a3", {16'd0, rom_a}, 32'h8006);
    chk("t1_data3", instr_data, 32'h0000_5A41);
    tick(); #1; chk("t1_pc4", {16'd0, instr_pc}, 32'h8003);
    // Redirect back to 8000 while the 4th instruction is being consumed
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h8000; #1;
    chk("t1_pc5", {16'd0, instr_pc}, 32'h8006);
    chk("t1_redir_re", {31'd0, rom_re}, 32'd0);

    // Test 2: back-pressure fills the skid
    push_exp(16'h8000, 3'd1); push_exp(16'h8001, 3'd2); push_exp(16'h8003, 3'd3);
    tick(); redirect_valid = 1'b0; #1;
    chk("t2_nv0", {31'd0, instr_valid}, 32'd0);
    chk("t2_a0", {16'd0, rom_a}, 32'h8000);
    tick(); #1; chk("t2_a1", {16'd0, rom_a}, 32'h8001);
    tick(); instr_ready = 1'b0; #1;
    chk("t2_pc_stall", {16'd0, instr_pc}, 32'h8000);
    chk("t2_re_stall", {31'd0, rom_re}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("t2_hold_pc", {16'd0, instr_pc}, 32'h8000);
      chk("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_hold_re", {31'd0, rom_re}, 32'd0);
    end
    tick(); instr_ready = 1'b1; #1;
    chk("t2_release_a", {16'd0, rom_a}, 32'h8003);
    chk("t2_release_re", {31'd0, rom_re}, 32'd1);
    tick(); #1;
    chk("t2_skid_pc", {16'd0, instr_pc}, 32'h8001);
    chk("t2_skid_len", {29'd0, instr_len}, 32'd2);
    chk("t2_a_next", {16'd0, rom_a}, 32'h8006);

    // Test 3: redirect with a response in flight
    push_exp(16'h9000, 3'd3);
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h9000; #1;
    chk("t3_pc", {16'd0, instr_pc}, 32'h8003);
    tick(); redirect_valid = 1'b0; #1;
    chk("t3_nv", {31'd0, instr_valid}, 32'd0);
    chk("t3_a", {16'd0, rom_a}, 32'h9000);
    tick(); #1; chk("t3_nv_dropped", {31'd0, instr_valid}, 32'd0);

    // Test 4: wrap past FFFF raises a fault at 0000
    push_exp(16'hFFFB, 3'd1); push_exp(16'hFFFC, 3'd4);
    tick(); redirect_valid = 1'b1; redirect_pc = 16'hFFFB; #1;
    chk("t3_first_pc", {16'd0, instr_pc}, 32'h9000);
    tick(); redirect_valid = 1'b0; #1;
    chk("t4_a0", {16'd0, rom_a}, 32'hFFFB);
    tick(); #1; chk("t4_a1", {16'd0, rom_a}, 32'hFFFC);
    tick(); #1;
    chk("t4_wrap_re", {31'd0, rom_re}, 32'd0);
    chk("t4_pc_fffb", {16'd0, instr_pc}, 32'hFFFB);
    tick(); #1;
    chk("t4_fault", {31'd0, fault}, 32'd1);
    chk("t4_fault_pc", {16'd0, fault_pc}, 32'h0000);
    chk("t4_data_fffc", instr_data, 32'h3322_11C0);
    tick(); #1;
    chk("t4_drained", {31'd0, instr_valid}, 32'd0);
    chk("t4_hold_re", {31'd0, rom_re}, 32'd0);
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h8000; #1;
    chk("t4_hold_fault", {31'd0, fault}, 32'd1);
    tick(); redirect_valid = 1'b0; #1;
    chk("t4_cleared", {31'd0, fault}, 32'd0);
    chk("t4_refetch", {16'd0, rom_a}, 32'h8000);

    // Test 5: redirect outside ROM faults without a request
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h1234; #1;
    tick(); redirect_valid = 1'b0; #1;
    chk("t5_re", {31'd0, rom_re}, 32'd0);
    chk("t5_nv", {31'd0, instr_valid}, 32'd0);
    tick(); #1;
    chk("t5_fault", {31'd0, fault}, 32'd1);
    chk("t5_fault_pc", {16'd0, fault_pc}, 32'h1234);
    chk("t5_re_hold", {31'd0, rom_re}, 32'd0);

    // Test 6: asynchronous reset mid-stream
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h8000; #1;
    tick(); redirect_valid = 1'b0; #1;
    chk("t6_a0", {16'd0, rom_a}, 32'h8000);
    tick(); #1;
    tick(); #1;
    chk("t6_pre_valid", {31'd0, instr_valid}, 32'd1);
    chk("t6_pre_re", {31'd0, rom_re}, 32'd1);
    #1; rst_n = 1'b0; #1;
    chk("t6_async_re", {31'd0, rom_re}, 32'd0);
    chk("t6_async_a", {16'd0, rom_a}, 32'd0);
    chk("t6_async_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_async_pc", {16'd0, instr_pc}, 32'd0);
    chk("t6_async_data", instr_data, 32'd0);
    tick(); #1;
    chk("t6_held_re", {31'd0, rom_re}, 32'd0);
    push_exp(16'h8000, 3'd1);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("t6_first_a", {16'd0, rom_a}, 32'h8000);
    tick(); #1; chk("t6_nv", {31'd0, instr_valid}, 32'd0);
    tick(); #1; chk("t6_pc0", {16'd0, instr_pc}, 32'h8000);
    tick(); instr_ready = 1'b0; #1;
    chk("t6_pc1", {16'd0, instr_pc}, 32'h8001);
    tick(); #1;
    tick(); #1;
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
